// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
//   Data-memory request/acknowledge bus between the memory stage (master) and
//   the data memory (slave).
//
//   mem_req    master->slave  request held high until mem_ack
//   mem_we     master->slave  1 = store, 0 = load
//   mem_addr   master->slave  word-aligned address {addr[31:2], 2'b00}
//   mem_be     master->slave  byte-lane enables
//   mem_wdata  master->slave  lane-replicated store data
//   mem_rdata  slave->master  read word, valid while mem_ack is high
//   mem_ack    slave->master  one-cycle completion pulse
// -----------------------------------------------------------------------------
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   Memory stage following the execute ALU. Performs RISC-V byte/half/word
//   loads and stores over a req/ack data-memory port with lane steering, byte
//   enables and sign/zero extension, and returns one registered result per
//   instruction together with a one-cycle done pulse and an error cause.
//
//   Parameters
//     TIMEOUT     cycles in REQ without mem_ack before a bus timeout (2..255)
//
//   Ports
//     clock       system clock, rising edge
//     reset       synchronous, active-low
//     valid_in    upstream instruction present (sampled in IDLE only)
//     alu_res     effective address or pass-through value
//     store_data  rs2 value for stores
//     funct3      000 B, 001 H, 010 W, 100 BU, 101 HU
//     mem_read    load instruction
//     mem_write   store instruction (wins over mem_read)
//     stall       upstream must hold its inputs
//     mem         data-memory bus (master side)
//     done        one-cycle pulse, result/err valid
//     result      extended load data, or alu_res
//     err         error flag qualified by done
//     err_cause   01 misaligned, 10 bus timeout, 11 illegal funct3
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [31:0]         alu_res,
    input  logic [31:0]         store_data,
    input  logic [2:0]          funct3,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic                stall,
    mem_access_stage_if.master  mem,
    output logic                done,
    output logic [31:0]         result,
    output logic                err,
    output logic [1:0]          err_cause
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,     state_d;
    logic        req_q,       req_d;
    logic        we_q,        we_d;
    logic [31:0] addr_q,      addr_d;
    logic [3:0]  be_q,        be_d;
    logic [31:0] wdata_q,     wdata_d;
    logic        done_q,      done_d;
    logic        err_q,       err_d;
    logic [1:0]  cause_q,     cause_d;
    logic [31:0] result_q,    result_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic [1:0]  lo_q,        lo_d;
    logic [2:0]  f3_q,        f3_d;
    logic [31:0] alu_q,       alu_d;

    // Byte enables for the addressed lane(s); size comes from funct3[1:0].
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across all lanes so the memory only has to
    // honour the byte enables.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{sd[7:0]}};
            2'b01:   wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] ext;
        sh = rd >> {lo, 3'b000};
        case (f3)
            3'b000:  ext = {{24{sh[7]}},  sh[7:0]};
            3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  ext = {24'd0, sh[7:0]};
            3'b101:  ext = {16'd0, sh[15:0]};
            default: ext = rd;
        endcase
        return ext;
    endfunction

    logic is_mem;
    logic f3_legal;
    logic misaligned;

    always_comb begin
        is_mem     = mem_read | mem_write;
        f3_legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b101);
        misaligned = ((funct3[1:0] == 2'b01) && alu_res[0]) ||
                     ((funct3[1:0] == 2'b10) && (alu_res[1:0] != 2'b00));
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        err_d    = err_q;
        cause_d  = cause_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        f3_d     = f3_q;
        alu_d    = alu_q;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (!is_mem) begin
                        result_d = alu_res;
                        done_d   = 1'b1;
                        state_d  = RESP;
                    end else if (!f3_legal) begin
                        err_d    = 1'b1;
                        cause_d  = 2'b11;
                        done_d   = 1'b1;
                        state_d  = RESP;
                    end else if (misaligned) begin
                        err_d    = 1'b1;
                        cause_d  = 2'b01;
                        result_d = alu_res;
                        done_d   = 1'b1;
                        state_d  = RESP;
                    end else begin
                        lo_d    = alu_res[1:0];
                        f3_d    = funct3;
                        alu_d   = alu_res;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = {alu_res[31:2], 2'b00};
                        be_d    = lane_be(funct3, alu_res[1:0]);
                        wdata_d = lane_wdata(funct3, store_data);
                        cnt_d   = 8'd0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem.mem_ack) begin
                    req_d    = 1'b0;
                    result_d = we_q ? alu_q : load_extend(f3_q, lo_q, mem.mem_rdata);
                    done_d   = 1'b1;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cause_d = 2'b10;
                    done_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                err_d   = 1'b0;
                cause_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cause_q  <= 2'b00;
            result_q <= 32'd0;
            cnt_q    <= 8'd0;
            lo_q     <= 2'b00;
            f3_q     <= 3'b000;
            alu_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cause_q  <= cause_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            f3_q     <= f3_d;
            alu_q    <= alu_d;
        end
    end

    assign stall         = ((state_q == IDLE) && valid_in) || (state_q == REQ);
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_cause     = cause_q;
    assign result        = result_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Directed and randomized stimulus for mem_access_stage with a behavioural
//   reference model of the expected bus activity and writeback result.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        err;
    logic [1:0]  err_cause;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_result = 32'd0;

    mem_access_stage_if mem_if ();

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .valid_in   (valid_in),
        .alu_res    (alu_res),
        .store_data (store_data),
        .funct3     (funct3),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .stall      (stall),
        .mem        (mem_if),
        .done       (done),
        .result     (result),
        .err        (err),
        .err_cause  (err_cause)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---- reference model: plain arithmetic on access size and byte offset ----
    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rd >> (8 * (a % 4));
        case (f3)
            3'b000:  begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'b001:  begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'b100:  v = sh & 32'hFF;
            3'b101:  v = sh & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        int mask;
        n    = acc_size(f3);
        mask = ((1 << n) - 1) << (a % 4);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (acc_size(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    // One instruction from IDLE to the cycle after its done pulse.
    // ack_dly: index of the REQ cycle that sees mem_ack, or -1 for no ack.
    task automatic do_op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdata, input int ack_dly);
        logic        is_mem;
        logic        legal;
        logic        mis;
        logic [31:0] exp_res;
        logic        exp_err;
        logic [1:0]  exp_cause;
        int          n;
        int          exp_cycles;
        is_mem = rd | wr;
        legal  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        mis    = legal && ((a % acc_size(f3)) != 0);

        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        alu_res    = a;
        store_data = sd;
        valid_in   = 1'b1;
        #1;
        chk({nm, "_stall_idle"}, stall, 1);
        tick();

        if (!is_mem || !legal || mis) begin
            exp_res   = (!is_mem || mis) ? a : model_result;
            exp_err   = is_mem;
            exp_cause = !is_mem ? 2'b00 : (!legal ? 2'b11 : 2'b01);
            chk({nm, "_done"},    done, 1);
            chk({nm, "_err"},     err, exp_err);
            chk({nm, "_cause"},   err_cause, exp_cause);
            chk({nm, "_result"},  result, exp_res);
            chk({nm, "_no_req"},  mem_if.mem_req, 0);
            chk({nm, "_stall_r"}, stall, 0);
        end else begin
            n = 0;
            while (!done && n < TO + 4) begin
                chk({nm, "_req"},   mem_if.mem_req, 1);
                chk({nm, "_we"},    mem_if.mem_we, wr);
                chk({nm, "_addr"},  mem_if.mem_addr, a & 32'hFFFF_FFFC);
                chk({nm, "_be"},    mem_if.mem_be, ref_be(f3, a));
                chk({nm, "_wdata"}, mem_if.mem_wdata, ref_wdata(f3, sd));
                chk({nm, "_stall"}, stall, 1);
                mem_if.mem_ack   = (n == ack_dly);
                mem_if.mem_rdata = (n == ack_dly) ? rdata : $urandom;
                tick();
                mem_if.mem_ack = 1'b0;
                n++;
            end
            if (ack_dly >= 0 && ack_dly < TO) begin
                exp_cycles = ack_dly + 1;
                exp_res    = wr ? a : ref_load(f3, a, rdata);
                exp_err    = 1'b0;
                exp_cause  = 2'b00;
            end else begin
                exp_cycles = TO;
                exp_res    = model_result;
                exp_err    = 1'b1;
                exp_cause  = 2'b10;
            end
            chk({nm, "_req_cycles"}, n, exp_cycles);
            chk({nm, "_done"},       done, 1);
            chk({nm, "_err"},        err, exp_err);
            chk({nm, "_cause"},      err_cause, exp_cause);
            chk({nm, "_result"},     result, exp_res);
            chk({nm, "_req_drop"},   mem_if.mem_req, 0);
            chk({nm, "_stall_r"},    stall, 0);
        end
        model_result = exp_res;

        valid_in = 1'b0;
        tick();
        chk({nm, "_done_low"},  done, 0);
        chk({nm, "_err_low"},   err, 0);
        chk({nm, "_cause_low"}, err_cause, 0);
        chk({nm, "_hold"},      result, model_result);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_rd;
        logic        r_wr;
        logic [2:0]  r_f3;
        logic [31:0] r_a;
        int          r_dly;
        logic [31:0] b2b_val;

        reset            = 1'b0;
        valid_in         = 1'b0;
        alu_res          = 32'd0;
        store_data       = 32'd0;
        funct3           = 3'd0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'd0;

        // ---- reset state ----
        repeat (3) tick();
        chk("rst_req",    mem_if.mem_req, 0);
        chk("rst_we",     mem_if.mem_we, 0);
        chk("rst_addr",   mem_if.mem_addr, 0);
        chk("rst_be",     mem_if.mem_be, 0);
        chk("rst_wdata",  mem_if.mem_wdata, 0);
        chk("rst_done",   done, 0);
        chk("rst_err",    err, 0);
        chk("rst_cause",  err_cause, 0);
        chk("rst_result", result, 0);
        chk("rst_stall",  stall, 0);
        reset = 1'b1;
        tick();

        // ---- ack while idle is ignored ----
        mem_if.mem_ack = 1'b1;
        tick();
        mem_if.mem_ack = 1'b0;
        chk("idle_ack_done", done, 0);
        chk("idle_ack_req",  mem_if.mem_req, 0);

        // ---- directed cases ----
        do_op("alu",     1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'd0, 32'd0, 0);
        do_op("lb",      1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_7F01, 0);
        do_op("lbu",     1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'h80FF_7F01, 0);
        do_op("sh",      1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 3);
        do_op("lw_mis",  1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 32'd0, 0);
        do_op("ld_ill",  1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'd0, 32'd0, 0);
        do_op("lw_to",   1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'd0, -1);
        do_op("lw_post", 1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'd0, 32'hCAFE_F00D, 1);
        do_op("lhu_hi",  1'b1, 1'b0, 3'b101, 32'h0000_5002, 32'd0, 32'h9ABC_1234, 2);
        do_op("rw_st",   1'b1, 1'b1, 3'b000, 32'h0000_6001, 32'h0000_00A5, 32'd0, 0);

        // ---- back-to-back valid_in: one done per instruction ----
        mem_read  = 1'b0;
        mem_write = 1'b0;
        b2b_val   = $urandom;
        alu_res   = b2b_val;
        valid_in  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("b2b_done", done, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 1) begin
                chk("b2b_result", result, b2b_val);
                b2b_val = $urandom;
                alu_res = b2b_val;
            end
        end
        valid_in = 1'b0;
        tick();
        model_result = result === 32'bx ? 32'd0 : result;
        chk("b2b_idle_done", done, 0);

        // ---- reset in the middle of a request ----
        do_op("pre_rst", 1'b0, 1'b0, 3'b000, 32'h1357_9BDF, 32'd0, 32'd0, 0);
        mem_read = 1'b1;
        funct3   = 3'b010;
        alu_res  = 32'h0000_7000;
        valid_in = 1'b1;
        tick();
        chk("mid_req_up", mem_if.mem_req, 1);
        tick();
        valid_in = 1'b0;
        reset    = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_req",    mem_if.mem_req, 0);
        chk("mid_rst_done",   done, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_stall",  stall, 0);
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_if.mem_ack = 1'b0;
        chk("late_ack_done1", done, 0);
        tick();
        chk("late_ack_done2", done, 0);
        chk("late_ack_res",   result, 0);
        model_result = 32'd0;

        // ---- randomized instructions ----
        for (int k = 0; k < 40; k++) begin
            r_rd = 1'($urandom_range(0, 1));
            r_wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       r_f3 = 3'b011;
                1:       r_f3 = 3'($urandom_range(6, 7));
                2, 3:    r_f3 = 3'b000;
                4:       r_f3 = 3'b100;
                5:       r_f3 = 3'b001;
                6:       r_f3 = 3'b101;
                default: r_f3 = 3'b010;
            endcase
            r_a   = $urandom;
            r_dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            do_op("rnd", r_rd, r_wr, r_f3, r_a, $urandom, $urandom, r_dly);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
